// File: rtl/minimig_sram_arbiter.sv
// Shares the SRAM bridge chipset port between the chipset bus and a host burst port.
// The host only gets bus slots in which the chipset leaves chip_bank at zero.
module minimig_sram_arbiter #(
    parameter int unsigned LEN_W = 3
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             c1_i,
    input  logic             c3_i,
    input  logic [7:0]       chip_bank_i,
    input  logic [23:1]      chip_address_i,
    input  logic [15:0]      chip_data_in_i,
    input  logic             chip_rd_i,
    input  logic             chip_hwr_i,
    input  logic             chip_lwr_i,
    output logic [15:0]      chip_data_out_o,
    input  logic             host_req_i,
    input  logic             host_we_i,
    input  logic [1:0]       host_bs_i,
    input  logic [7:0]       host_bank_i,
    input  logic [23:1]      host_address_i,
    input  logic [LEN_W-1:0] host_len_i,
    input  logic [15:0]      host_wdata_i,
    output logic             host_busy_o,
    output logic             host_ack_o,
    output logic             host_done_o,
    output logic [15:0]      host_rdata_o,
    output logic [7:0]       ram_bank_o,
    output logic [23:1]      ram_address_o,
    output logic [15:0]      ram_data_o,
    output logic             ram_rd_o,
    output logic             ram_hwr_o,
    output logic             ram_lwr_o,
    input  logic [15:0]      ram_q_i
);

    localparam int unsigned WRAP_W = 18;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_WAIT   = 2'd1,
        ST_ACCESS = 2'd2
    } state_t;

    state_t state_q, state_d;

    logic             we_q, we_d;
    logic [1:0]       bs_q, bs_d;
    logic [7:0]       bank_q, bank_d;
    logic [23:1]      addr_q, addr_d;
    logic [LEN_W-1:0] cnt_q, cnt_d;
    logic [15:0]      wdata_q, wdata_d;
    logic             first_q, first_d;
    logic             busy_q, busy_d;
    logic             ack_q, ack_d;
    logic             done_q, done_d;
    logic [15:0]      rdata_q, rdata_d;

    logic ph_q0, ph_q3, ph_q12, grant, chip_idle;

    assign ph_q0     = c1_i & ~c3_i;
    assign ph_q3     = ~c1_i & ~c3_i;
    assign ph_q12    = c3_i;
    assign chip_idle = (chip_bank_i == 8'd0);
    assign grant     = (state_q == ST_ACCESS);

    // State register; async reset drops the grant immediately.
    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:   if (host_req_i) state_d = ST_WAIT;
            ST_WAIT:   if (ph_q0 && chip_idle) state_d = ST_ACCESS;
            ST_ACCESS: if (ph_q3) state_d = (cnt_q == '0) ? ST_IDLE : ST_WAIT;
            default:   state_d = ST_IDLE;
        endcase
    end

    // Port mux: the chipset passes straight through unless the host holds the slot.
    always_comb begin
        ram_bank_o      = chip_bank_i;
        ram_address_o   = chip_address_i;
        ram_data_o      = chip_data_in_i;
        ram_rd_o        = chip_rd_i;
        ram_hwr_o       = chip_hwr_i;
        ram_lwr_o       = chip_lwr_i;
        chip_data_out_o = ram_q_i;
        if (grant) begin
            ram_bank_o      = bank_q;
            ram_address_o   = addr_q;
            ram_data_o      = wdata_q;
            ram_rd_o        = ~we_q & ~ph_q0;
            // Write strobes drop in Q3 so data is held past the strobe edge.
            ram_hwr_o       = we_q & bs_q[1] & ph_q12;
            ram_lwr_o       = we_q & bs_q[0] & ph_q12;
            chip_data_out_o = 16'd0;
        end
    end

    // Burst datapath next-state.
    always_comb begin
        we_d    = we_q;
        bs_d    = bs_q;
        bank_d  = bank_q;
        addr_d  = addr_q;
        cnt_d   = cnt_q;
        wdata_d = wdata_q;
        first_d = first_q;
        busy_d  = busy_q;
        ack_d   = 1'b0;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        unique case (state_q)
            ST_IDLE: begin
                if (host_req_i) begin
                    we_d    = host_we_i;
                    bs_d    = host_bs_i;
                    bank_d  = host_bank_i;
                    addr_d  = host_address_i;
                    cnt_d   = host_len_i;
                    wdata_d = host_wdata_i;
                    first_d = 1'b1;
                    busy_d  = 1'b1;
                end
            end
            ST_WAIT: begin
                // First word's data was captured with the request.
                if (ph_q0 && chip_idle && !first_q) wdata_d = host_wdata_i;
            end
            ST_ACCESS: begin
                if (ph_q3) begin
                    ack_d   = 1'b1;
                    first_d = 1'b0;
                    if (!we_q) rdata_d = (bank_q != 8'd0) ? ram_q_i : 16'd0;
                    addr_d  = {addr_q[23:19], WRAP_W'(addr_q[18:1] + WRAP_W'(1))};
                    cnt_d   = cnt_q - LEN_W'(1);
                    if (cnt_q == '0) begin
                        done_d = 1'b1;
                        busy_d = 1'b0;
                    end
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk_i or posedge reset_i) begin
        if (reset_i) begin
            we_q    <= 1'b0;
            bs_q    <= 2'b00;
            bank_q  <= 8'd0;
            addr_q  <= '0;
            cnt_q   <= '0;
            wdata_q <= 16'd0;
            first_q <= 1'b0;
            busy_q  <= 1'b0;
            ack_q   <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= 16'd0;
        end else begin
            we_q    <= we_d;
            bs_q    <= bs_d;
            bank_q  <= bank_d;
            addr_q  <= addr_d;
            cnt_q   <= cnt_d;
            wdata_q <= wdata_d;
            first_q <= first_d;
            busy_q  <= busy_d;
            ack_q   <= ack_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
        end
    end

    assign host_busy_o  = busy_q;
    assign host_ack_o   = ack_q;
    assign host_done_o  = done_q;
    assign host_rdata_o = rdata_q;

endmodule

// File: tb/tb_minimig_sram_arbiter.sv
// Directed bench for minimig_sram_arbiter with a small word-wide SRAM bridge model.
module tb_minimig_sram_arbiter;

    localparam int unsigned LEN_W = 3;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic             reset;
    logic             c1, c3;
    logic [7:0]       chip_bank;
    logic [23:1]      chip_address;
    logic [15:0]      chip_data_in;
    logic             chip_rd, chip_hwr, chip_lwr;
    logic [15:0]      chip_data_out;
    logic             host_req, host_we;
    logic [1:0]       host_bs;
    logic [7:0]       host_bank;
    logic [23:1]      host_address;
    logic [LEN_W-1:0] host_len;
    logic [15:0]      host_wdata;
    logic             host_busy, host_ack, host_done;
    logic [15:0]      host_rdata;
    logic [7:0]       ram_bank;
    logic [23:1]      ram_address;
    logic [15:0]      ram_data;
    logic             ram_rd, ram_hwr, ram_lwr;
    logic [15:0]      ram_q;

    minimig_sram_arbiter #(.LEN_W(LEN_W)) dut (
        .clk_i(clk), .reset_i(reset), .c1_i(c1), .c3_i(c3),
        .chip_bank_i(chip_bank), .chip_address_i(chip_address),
        .chip_data_in_i(chip_data_in), .chip_rd_i(chip_rd),
        .chip_hwr_i(chip_hwr), .chip_lwr_i(chip_lwr),
        .chip_data_out_o(chip_data_out),
        .host_req_i(host_req), .host_we_i(host_we), .host_bs_i(host_bs),
        .host_bank_i(host_bank), .host_address_i(host_address),
        .host_len_i(host_len), .host_wdata_i(host_wdata),
        .host_busy_o(host_busy), .host_ack_o(host_ack), .host_done_o(host_done),
        .host_rdata_o(host_rdata),
        .ram_bank_o(ram_bank), .ram_address_o(ram_address), .ram_data_o(ram_data),
        .ram_rd_o(ram_rd), .ram_hwr_o(ram_hwr), .ram_lwr_o(ram_lwr),
        .ram_q_i(ram_q)
    );

    // SRAM model: 1K words indexed by low address bits, inert when no bank is selected.
    logic [15:0] mem [0:1023];
    logic        mem_clr;
    always_ff @(posedge clk) begin
        if (mem_clr) begin
            for (int i = 0; i < 1024; i++) mem[i] <= 16'd0;
        end else if (ram_bank != 8'd0) begin
            if (ram_hwr) mem[ram_address[10:1]][15:8] <= ram_data[15:8];
            if (ram_lwr) mem[ram_address[10:1]][7:0]  <= ram_data[7:0];
        end
    end
    assign ram_q = (ram_bank != 8'd0 && ram_rd) ? mem[ram_address[10:1]] : 16'd0;

    int ph;
    int cyc;
    int checks;
    int failures;
    int strobe_bad;
    logic [23:1] wr_addr_log [$];
    logic [15:0] wr_data_log [$];

    // Write-strobe monitor: log at Q1, flag any strobe seen in Q0 or Q3.
    always @(posedge clk) begin
        if (!reset && (ram_hwr || ram_lwr)) begin
            if (ph == 1) begin
                wr_addr_log.push_back(ram_address);
                wr_data_log.push_back(ram_data);
            end
            if (ph == 0 || ph == 3) strobe_bad++;
        end
    end

    typedef struct {
        logic        we;
        logic [1:0]  bs;
        logic [7:0]  bank;
        logic [23:1] addr;
        logic [15:0] wdata;
        logic        chk;
        logic [15:0] exp_rdata;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        ph  = (ph + 1) % 4;
        c1  = (ph == 0 || ph == 1);
        c3  = (ph == 1 || ph == 2);
        cyc++;
    endtask

    // Presents a request during Q3 and returns after the accepting edge.
    task automatic host_start(input logic we, input logic [1:0] bs, input logic [7:0] bank,
                              input logic [23:1] addr, input logic [LEN_W-1:0] len,
                              input logic [15:0] wdata);
        int n;
        n = 0;
        while (ph != 3 && n < 8) begin
            step();
            n++;
        end
        host_req     = 1'b1;
        host_we      = we;
        host_bs      = bs;
        host_bank    = bank;
        host_address = addr;
        host_len     = len;
        host_wdata   = wdata;
        step();
        host_req     = 1'b0;
    endtask

    task automatic wait_ack(output int n);
        n = 0;
        while (!host_ack && n < 200) begin
            step();
            n++;
        end
    endtask

    task automatic run_vec(input vec_t v, input int idx);
        int n;
        host_start(v.we, v.bs, v.bank, v.addr, '0, v.wdata);
        check($sformatf("v%0d_busy_after_accept", idx), 32'(host_busy), 32'd1);
        wait_ack(n);
        check($sformatf("v%0d_ack_latency", idx), 32'(n), 32'd4);
        check($sformatf("v%0d_done_with_ack", idx), 32'(host_done), 32'd1);
        check($sformatf("v%0d_busy_low", idx), 32'(host_busy), 32'd0);
        if (v.chk) check($sformatf("v%0d_rdata", idx), 32'(host_rdata), 32'(v.exp_rdata));
    endtask

    initial begin
        int n, k, guard, last, t0, slot, acks, disturbed, granted;
        logic [15:0] wd [4];
        logic [23:1] exp_addr [4];
        logic [15:0] exp_rd [8];
        vec_t fresh;

        checks = 0; failures = 0; strobe_bad = 0; cyc = 0;
        ph = 3; c1 = 1'b0; c3 = 1'b0;
        reset = 1'b1; mem_clr = 1'b1;
        host_req = 1'b0; host_we = 1'b0; host_bs = 2'b00; host_bank = 8'd0;
        host_address = '0; host_len = '0; host_wdata = 16'd0;
        chip_bank = 8'h04; chip_address = 23'h012345; chip_data_in = 16'hC0DE;
        chip_rd = 1'b1; chip_hwr = 1'b0; chip_lwr = 1'b1;

        vecs[0] = '{1'b1, 2'b11, 8'h01, 23'h000100, 16'h5A5A, 1'b0, 16'h0000};
        vecs[1] = '{1'b0, 2'b00, 8'h01, 23'h000100, 16'h0000, 1'b1, 16'h5A5A};
        vecs[2] = '{1'b1, 2'b11, 8'h01, 23'h000200, 16'hFFFF, 1'b0, 16'h0000};
        vecs[3] = '{1'b1, 2'b01, 8'h01, 23'h000200, 16'hABCD, 1'b0, 16'h0000};
        vecs[4] = '{1'b0, 2'b00, 8'h01, 23'h000200, 16'h0000, 1'b1, 16'hFFCD};
        vecs[5] = '{1'b1, 2'b10, 8'h02, 23'h000201, 16'h1234, 1'b0, 16'h0000};
        vecs[6] = '{1'b0, 2'b00, 8'h02, 23'h000201, 16'h0000, 1'b1, 16'h1200};
        vecs[7] = '{1'b0, 2'b00, 8'h00, 23'h000100, 16'h0000, 1'b1, 16'h0000};

        step(); step(); step();
        check("rst_busy", 32'(host_busy), 32'd0);
        check("rst_ack", 32'(host_ack), 32'd0);
        check("rst_done", 32'(host_done), 32'd0);
        check("rst_rdata", 32'(host_rdata), 32'd0);
        check("rst_ram_bank", 32'(ram_bank), 32'h04);
        check("rst_ram_address", 32'(ram_address), 32'h012345);
        check("rst_ram_data", 32'(ram_data), 32'hC0DE);
        check("rst_ram_strobes", 32'({ram_rd, ram_hwr, ram_lwr}), 32'b101);

        chip_bank = 8'd0; chip_address = '0; chip_data_in = 16'd0;
        chip_rd = 1'b0; chip_hwr = 1'b0; chip_lwr = 1'b0;
        step();
        mem_clr = 1'b0;
        reset = 1'b0;
        step();

        for (int i = 0; i < 8; i++) run_vec(vecs[i], i);

        // Write burst across the 2^18-word wrap point.
        wd = '{16'h1111, 16'h2222, 16'h3333, 16'h4444};
        exp_addr = '{23'h03FFFE, 23'h03FFFF, 23'h000000, 23'h000001};
        wr_addr_log.delete();
        wr_data_log.delete();
        strobe_bad = 0;
        host_start(1'b1, 2'b11, 8'h01, 23'h03FFFE, 3'd3, wd[0]);
        t0 = cyc; last = cyc; k = 0; guard = 0;
        while (k < 4 && guard < 100) begin
            step();
            guard++;
            if (host_ack) begin
                check($sformatf("burst_gap%0d", k), 32'(cyc - last), 32'd4);
                check($sformatf("burst_done%0d", k), 32'(host_done), 32'(k == 3));
                last = cyc;
                k++;
                if (k < 4) host_wdata = wd[k];
            end
        end
        check("burst_acks", 32'(k), 32'd4);
        check("burst_busy_end", 32'(host_busy), 32'd0);
        check("burst_log_len", 32'(wr_addr_log.size()), 32'd4);
        for (int i = 0; i < 4 && i < wr_addr_log.size(); i++) begin
            check($sformatf("burst_addr%0d", i), 32'(wr_addr_log[i]), 32'(exp_addr[i]));
            check($sformatf("burst_data%0d", i), 32'(wr_data_log[i]), 32'(wd[i]));
        end
        check("burst_strobe_phase", 32'(strobe_bad), 32'd0);

        // Chipset owns five slots; a second request while busy must be ignored.
        chip_bank = 8'h20; chip_rd = 1'b1; chip_address = 23'h000100;
        host_start(1'b0, 2'b00, 8'h01, 23'h000200, 3'd0, 16'h0000);
        granted = 0;
        for (int i = 1; i <= 20; i++) begin
            host_req = (i == 5);
            host_address = (i == 5) ? 23'h000100 : 23'h000200;
            step();
            if (host_ack || ram_bank != 8'h20) granted++;
            if (i == 10) check("chipbusy_data_out", 32'(chip_data_out), 32'h5A5A);
        end
        host_req = 1'b0;
        check("chipbusy_no_grant", 32'(granted), 32'd0);
        check("chipbusy_still_busy", 32'(host_busy), 32'd1);
        chip_bank = 8'd0; chip_rd = 1'b0;
        wait_ack(n);
        check("chipbusy_ack_latency", 32'(n), 32'd4);
        check("chipbusy_rdata", 32'(host_rdata), 32'hFFCD);
        check("chipbusy_done", 32'(host_done), 32'd1);

        // Read burst with alternating chipset/idle slots.
        exp_rd = '{16'h0000, 16'h0000, 16'h1111, 16'h2222,
                   16'h3333, 16'h4444, 16'h0000, 16'h0000};
        chip_bank = 8'h20; chip_rd = 1'b1; chip_address = 23'h000200;
        host_start(1'b0, 2'b00, 8'h01, 23'h03FFFC, 3'd7, 16'h0000);
        t0 = cyc; last = cyc; slot = 0; acks = 0; guard = 0; disturbed = 0;
        while (acks < 8 && guard < 120) begin
            step();
            guard++;
            if (host_ack) begin
                check($sformatf("alt_gap%0d", acks), 32'(cyc - last), 32'd8);
                check($sformatf("alt_rdata%0d", acks), 32'(host_rdata), 32'(exp_rd[acks]));
                last = cyc;
                acks++;
                if (acks == 8) check("alt_done", 32'(host_done), 32'd1);
            end
            if (ph == 0) begin
                slot++;
                chip_bank = (slot % 2 == 0) ? 8'h20 : 8'h00;
                chip_rd = (slot % 2 == 0);
            end
            #1;
            if (chip_bank != 8'd0 && (ram_bank != chip_bank || chip_data_out != 16'hFFCD))
                disturbed++;
        end
        check("alt_acks", 32'(acks), 32'd8);
        check("alt_chip_undisturbed", 32'(disturbed), 32'd0);
        chip_bank = 8'd0; chip_rd = 1'b0;

        // Reset asserted during Q2 of a granted write.
        host_start(1'b1, 2'b11, 8'h01, 23'h000300, 3'd0, 16'h7777);
        step();
        step();
        check("rstmid_pre_hwr", 32'(ram_hwr), 32'd1);
        reset = 1'b1;
        #1;
        check("rstmid_strobes", 32'({ram_hwr, ram_lwr, ram_rd}), 32'd0);
        check("rstmid_bank", 32'(ram_bank), 32'd0);
        check("rstmid_busy", 32'(host_busy), 32'd0);
        step();
        step();
        check("rstmid_ack_done", 32'({host_ack, host_done}), 32'd0);
        reset = 1'b0;
        step();
        fresh = '{1'b0, 2'b00, 8'h01, 23'h000100, 16'h0000, 1'b1, 16'h5A5A};
        run_vec(fresh, 8);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/minimig_sram_arbiter.md
# minimig_sram_arbiter

Shares the single chipset-side port of the SRAM bridge between the chipset bus and a secondary host port (OSD/loader/DMA). The chipset always owns a bus slot in which it selects a bank. The host is granted only slots in which the chipset is idle, and it gets a fixed three-phase SRAM cycle per word, with burst support. The block sits directly in front of the SRAM bridge and drives its bank/address/data/strobe inputs.

## Interface
- LEN_W, 3, width of host burst length field; a burst is host_len+1 words (max 2^LEN_W)
- clk  in  1  28 MHz system clock
- reset  in  1  asynchronous, active-high
- c1, c3  in  1 each  bus phase enables; Q0=c1&!c3, Q1=c1&c3, Q2=!c1&c3, Q3=!c1&!c3
- chip_bank  in  8  chipset bank select; nonzero = chipset access this slot
- chip_address  in  23 [23:1]  chipset address
- chip_data_in  in  16  chipset write data
- chip_rd, chip_hwr, chip_lwr  in  1 each  chipset strobes
- chip_data_out  out  16  read data to chipset
- host_req  in  1  start burst; sampled only while host_busy=0
- host_we  in  1  1=write, 0=read
- host_bs  in  2  byte selects {high, low}; used for writes only
- host_bank  in  8  bank select for the burst; must be nonzero, one-hot
- host_address  in  23 [23:1]  start word address
- host_len  in  LEN_W  words minus one
- host_wdata  in  16  write data for the current word
- host_busy  out  1  burst accepted and not finished
- host_ack  out  1  one-clk pulse per completed word
- host_done  out  1  one-clk pulse, coincident with final host_ack
- host_rdata  out  16  read word; valid while host_ack=1, held until next ack
- ram_bank  out  8; ram_address  out  23 [23:1]; ram_data  out  16; ram_rd, ram_hwr, ram_lwr  out  1 each  to bridge port
- ram_q  in  16  bridge read data

## Operation
- States: IDLE, WAIT (pending, no grant), ACCESS (granted slot, phases Q1..Q3).
- IDLE: when host_req=1, latch we, bs, bank, address, len, and wdata at the clk edge. Go to WAIT and set host_busy=1.
- WAIT: at the clk edge ending a Q0 cycle, if chip_bank==0, set grant=1 and go to ACCESS. For writes, latch host_wdata for words after the first.
- If chip_bank!=0, stay in WAIT. There is no timeout: the host may wait indefinitely.
- ACCESS spans the Q1, Q2 and Q3 cycles. At the edge ending Q3:
  - clear grant and pulse host_ack.
  - On reads, capture ram_q into host_rdata.
  - Increment address bits [18:1] mod 2^18. Bits [23:19] are held, so a burst wraps inside its 512 KB bank.
  - Decrement the word counter. If the counter was 0, pulse host_done, clear host_busy and go to IDLE. Otherwise go to WAIT.
- Mux, grant=0: ram_* equal chip_* combinationally, and chip_data_out=ram_q.
- Mux, grant=1:
  - ram_bank=latched bank and ram_address=current address. ram_data=latched wdata.
  - ram_rd=!we during Q1..Q3.
  - ram_hwr=we&bs[1] and ram_lwr=we&bs[0], during Q1..Q2 only; released in Q3 for data hold.
  - chip_data_out=0.
- The chipset must hold bank, address and strobes stable for the whole slot. The host must present the next word's wdata between host_ack and the next grant.
- host_bank==0 is illegal. The cycle still runs but the bridge does nothing, and host_rdata returns 0.
- A host_req while host_busy=1 is ignored. host_req in the same cycle as host_done is ignored; it is sampled on the following cycle.

## Timing
- Reset values: state IDLE, grant=0, host_busy=0, host_ack=0, host_done=0, host_rdata=0, counter=0. ram_* pass chip_* during reset.
- Reset mid-burst: grant drops asynchronously and strobes return to chip_*. No ack or done is issued.
- Best-case latency: if host_req is sampled in Q3, the grant lands at the end of the next Q0. host_ack occurs 4 clks after the sampling edge, at the edge ending Q3.
- Throughput: at most one host word per 4-clk slot. Consecutive idle slots give back-to-back acks every 4 clks.
- host_busy falls at the same edge at which host_done and the final host_ack rise.
- c1/c3 are sampled with clk only. The grant decision uses chip_bank as seen during Q0.

## Test plan
- Reset low, chipset idle: host read, bank=0x01, address=0x000100, len=0. Expect host_ack and host_done on the same clk 4 clks after acceptance, host_rdata=SRAM[0x000100], and busy low at that edge.
- Host write burst, len=3, bs=2'b11, data 0x1111/0x2222/0x3333/0x4444 from address 0x03FFFE. Expect 4 acks 4 clks apart and addresses 0x03FFFE, 0x03FFFF, 0x000000, 0x000001 (wrap in bank). ram_hwr/ram_lwr must be high only in Q1..Q2.
- Chipset busy for 5 slots (chip_bank=0x20) while host_req pending. Expect no grant, chip_data_out tracking ram_q, then a grant in the first slot with chip_bank=0.
- Alternating chip/idle slots during a host read of len=7. Expect 8 acks spaced 8 clks apart, and no chipset slot disturbed.
- Byte write bs=2'b01 with value 0xABCD over 0xFFFF. Readback expects 0xFFCD.
- Assert reset during Q2 of a granted write. Expect strobes to drop immediately, busy/ack/done at 0, and a fresh request to work after reset is released.
